regfile_scoreboard: RTL
=======================

Name: regfile_scoreboard

Overview:
Parametrised successor to the core register file. It provides two combinational read ports and two write ports: port 0 for the single-cycle ALU result and port 1 for long-latency results (loads, multiplies). It also keeps a per-register busy scoreboard so the issue stage can detect RAW hazards against outstanding long-latency writes. It sits in the decode/writeback boundary of the pipeline and replaces the single-write-port file.

Parameters:
DATA_W, 64, register width in bits
ADDR_W, 5, register index width; depth = 2**ADDR_W
HAS_ZERO, 1, 1 = index ZERO_REG is hardwired to zero; 0 = all registers writable
ZERO_REG, 31, index of the hardwired-zero register (ignored when HAS_ZERO=0)

Ports:
Clk  input  1  clock, all state updates on rising edge
resetl  input  1  asynchronous active-low reset
RA  input  ADDR_W  read port A index
RB  input  ADDR_W  read port B index
BusA  output  DATA_W  read data A (combinational)
BusB  output  DATA_W  read data B (combinational)
BusAValid  output  1  1 = BusA holds committed or bypassed final value
BusBValid  output  1  same for BusB
RW  input  ADDR_W  write port 0 index
BusW  input  DATA_W  write port 0 data
RegWr  input  1  write port 0 enable
RW1  input  ADDR_W  write port 1 index (long-latency return)
BusW1  input  DATA_W  write port 1 data
RegWr1  input  1  write port 1 enable; clears busy bit of RW1
Reserve  input  1  mark RD busy (long-latency op issued)
RD  input  ADDR_W  register to reserve
Busy  output  2**ADDR_W  registered busy bit vector
BusyCount  output  ADDR_W+1  number of set busy bits (registered)
ErrWAW  output  1  sticky hazard error flag

Behaviour:
- Reset (resetl=0, asynchronous): all registers 0, Busy 0, BusyCount 0, ErrWAW 0. Reads during reset return 0 with Valid=1. Reset mid-operation discards all outstanding reservations.
- "Zero index": HAS_ZERO=1 and index==ZERO_REG. It reads 0 with Valid=1. Writes, reserves and bypass to it are ignored and never raise ErrWAW.
- Writes commit at the rising edge. Same-cycle read of the register being written returns the new data via bypass (half-cycle write/read emulation).
- Read priority for port X (A/B), index R:
  - zero index -> 0;
  - else RegWr && RW==R -> BusW;
  - else RegWr1 && RW1==R -> BusW1;
  - else array[R].
- Valid for index R = zero index OR !Busy[R] OR (RegWr1 && RW1==R).
- Port 0 bypassing a busy register does not set Valid.
- Dual write to the same index in one cycle: port 0 data is stored; busy is still cleared by port 1.
- Busy update per edge, for each non-zero index i:
  - set if Reserve && RD==i;
  - else clear if RegWr1 && RW1==i;
  - else hold.
  - Reserve and clear of the same register in the same cycle leaves it busy (new reservation wins).
- RegWr1 to a non-busy register still writes; busy stays 0; no error.
- ErrWAW is set (sticky until reset) on either condition:
  - Reserve to a non-zero RD with Busy[RD]=1 and not cleared by RegWr1 in the same cycle;
  - RegWr with Busy[RW]=1 (non-zero RW).
  - The offending write/reserve is still performed.
- BusyCount tracks popcount(Busy) and updates in the same edge as Busy. It is maintained incrementally: +1 on net set, −1 on net clear, 0 when the events cancel or on a re-reserve. It never exceeds 2**ADDR_W − HAS_ZERO.
- No X propagation: RegWr/RegWr1/Reserve treated as 0 unless exactly 1.

Test Plan:
- Reset mid-run: write R3=0x55, reserve R4, assert resetl=0 between clock edges -> BusA(RA=3)=0, Busy=0, BusyCount=0, ErrWAW=0 immediately, without waiting for Clk.
- Bypass/priority: RW=5, BusW=0xAAAA, RW1=5, BusW1=0xBBBB, both enables, RA=5 -> BusA=0xAAAA same cycle; next cycle RegWr=0 -> BusA=0xAAAA.
- Scoreboard: Reserve RD=7 -> Busy[7]=1, BusyCount=1, BusAValid(RA=7)=0. Two cycles later RegWr1 RW1=7, BusW1=0x1234 -> same cycle BusA=0x1234, Valid=1. Next cycle Busy[7]=0, BusyCount=0.
- Simultaneous reserve+clear: Busy[9]=1, Reserve RD=9 with RegWr1 RW1=9 -> Busy[9] stays 1, BusyCount unchanged, ErrWAW=0.
- Hazards: Reserve RD=2 twice on consecutive cycles -> ErrWAW=1 after second edge and sticky. Separately, after reset, RegWr RW=2 while Busy[2]=1 -> ErrWAW=1, R2 written.
- Zero register: RegWr RW=31 BusW=0xFFFF, Reserve RD=31 -> BusA(RA=31)=0, Valid=1, Busy[31]=0, BusyCount=0, ErrWAW=0. With HAS_ZERO=0, R31 stores 0xFFFF.

Source files
------------

// File: rtl/regfile_scoreboard_if.sv
// Bus bundle for regfile_scoreboard: read ports, two write ports, reservation
// request, and the registered scoreboard status returned to the issue stage.
interface regfile_scoreboard_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0]     RA;
  logic [ADDR_W-1:0]     RB;
  logic [DATA_W-1:0]     BusA;
  logic [DATA_W-1:0]     BusB;
  logic                  BusAValid;
  logic                  BusBValid;
  logic [ADDR_W-1:0]     RW;
  logic [DATA_W-1:0]     BusW;
  logic                  RegWr;
  logic [ADDR_W-1:0]     RW1;
  logic [DATA_W-1:0]     BusW1;
  logic                  RegWr1;
  logic                  Reserve;
  logic [ADDR_W-1:0]     RD;
  logic [2**ADDR_W-1:0]  Busy;
  logic [ADDR_W:0]       BusyCount;
  logic                  ErrWAW;

  modport master (
    output RA, RB, RW, BusW, RegWr, RW1, BusW1, RegWr1, Reserve, RD,
    input  BusA, BusB, BusAValid, BusBValid, Busy, BusyCount, ErrWAW
  );

  modport slave (
    input  RA, RB, RW, BusW, RegWr, RW1, BusW1, RegWr1, Reserve, RD,
    output BusA, BusB, BusAValid, BusBValid, Busy, BusyCount, ErrWAW
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Two-read / two-write register file with write-through bypass and a busy
// scoreboard tracking outstanding long-latency writes for RAW/WAW detection.
module regfile_scoreboard #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int HAS_ZERO = 1,
  parameter int ZERO_REG = 31
) (
  input  logic                 Clk,
  input  logic                 resetl,
  regfile_scoreboard_if.slave  bus
);
  localparam int  DEPTH   = 2**ADDR_W;
  localparam int  CNT_W   = ADDR_W + 1;
  localparam bit  ZERO_EN = (HAS_ZERO != 0);
  localparam logic [ADDR_W-1:0] ZERO_IDX = ZERO_REG[ADDR_W-1:0];

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              err_q;
  logic              err_d;

  logic              wr0_en;
  logic              wr1_en;
  logic              res_en;
  logic              wr0_ok;
  logic              wr1_ok;
  logic              res_ok;
  logic [DEPTH-1:0]  set_vec;
  logic [DEPTH-1:0]  clr_vec;
  logic              cnt_inc;
  logic              cnt_dec;
  logic              haz_res;
  logic              haz_wr0;

  logic [ADDR_W-1:0] rd_idx   [2];
  logic [DATA_W-1:0] rd_data  [2];
  logic              rd_valid [2];

  function automatic logic is_zero(input logic [ADDR_W-1:0] idx);
    return ZERO_EN && (idx == ZERO_IDX);
  endfunction

  // X-safe enables: anything other than a clean 1 is treated as idle
  assign wr0_en = (bus.RegWr   === 1'b1);
  assign wr1_en = (bus.RegWr1  === 1'b1);
  assign res_en = (bus.Reserve === 1'b1);

  assign wr0_ok = wr0_en && !is_zero(bus.RW);
  assign wr1_ok = wr1_en && !is_zero(bus.RW1);
  assign res_ok = res_en && !is_zero(bus.RD);

  // Decode reservation and long-latency return into per-register set/clear
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (res_ok) begin
      set_vec[bus.RD] = 1'b1;
    end else begin
      set_vec = '0;
    end
    if (wr1_ok) begin
      clr_vec[bus.RW1] = 1'b1;
    end else begin
      clr_vec = '0;
    end
  end

  // Next busy vector: a new reservation wins over a same-cycle clear
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (set_vec[i]) begin
        busy_d[i] = 1'b1;
      end else if (clr_vec[i]) begin
        busy_d[i] = 1'b0;
      end else begin
        busy_d[i] = busy_q[i];
      end
    end
  end

  // Incremental popcount: re-reserve is a no-op, cancelling set/clear nets zero
  always_comb begin
    cnt_inc = res_ok && !busy_q[bus.RD];
    cnt_dec = wr1_ok && busy_q[bus.RW1] && !(res_ok && (bus.RD == bus.RW1));
    cnt_d   = cnt_q + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
  end

  // WAW hazards against outstanding long-latency writes
  always_comb begin
    haz_res = res_ok && busy_q[bus.RD] && !(wr1_ok && (bus.RW1 == bus.RD));
    haz_wr0 = wr0_ok && busy_q[bus.RW];
    if (haz_res || haz_wr0) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Register array: port 0 is applied last so it wins a dual write
  always_ff @(posedge Clk or negedge resetl) begin
    if (!resetl) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (wr1_ok) begin
        mem_q[bus.RW1] <= bus.BusW1;
      end
      if (wr0_ok) begin
        mem_q[bus.RW] <= bus.BusW;
      end
    end
  end

  // Scoreboard state and sticky error
  always_ff @(posedge Clk or negedge resetl) begin
    if (!resetl) begin
      busy_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign rd_idx[0] = bus.RA;
  assign rd_idx[1] = bus.RB;

  // Read ports with bypass; reset forces 0/valid regardless of pending writes
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p]  = '0;
      rd_valid[p] = 1'b1;
      if (!resetl) begin
        rd_data[p]  = '0;
        rd_valid[p] = 1'b1;
      end else if (is_zero(rd_idx[p])) begin
        rd_data[p]  = '0;
        rd_valid[p] = 1'b1;
      end else begin
        if (wr0_en && (bus.RW == rd_idx[p])) begin
          rd_data[p] = bus.BusW;
        end else if (wr1_en && (bus.RW1 == rd_idx[p])) begin
          rd_data[p] = bus.BusW1;
        end else begin
          rd_data[p] = mem_q[rd_idx[p]];
        end
        rd_valid[p] = !busy_q[rd_idx[p]] || (wr1_en && (bus.RW1 == rd_idx[p]));
      end
    end
  end

  assign bus.BusA      = rd_data[0];
  assign bus.BusB      = rd_data[1];
  assign bus.BusAValid = rd_valid[0];
  assign bus.BusBValid = rd_valid[1];
  assign bus.Busy      = busy_q;
  assign bus.BusyCount = cnt_q;
  assign bus.ErrWAW    = err_q;

endmodule
